// File: rtl/lock_controller.sv
// Keypad lock controller: counts digits, checks the entered code on ENTER,
// holds the lock open, counts failures, locks out and allows reprogramming.
module lock_controller #(
    parameter int                  DIGITS         = 4,
    parameter logic [4*DIGITS-1:0] DEFAULT_CODE   = 16'h1234,
    parameter int                  OPEN_CYCLES    = 8,
    parameter int                  MAX_FAIL       = 3,
    parameter int                  LOCKOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  digit_valid,
    input  logic                  enter,
    input  logic                  prog,
    input  logic [4*DIGITS-1:0]   code_i,
    output logic                  shift_clr,
    output logic                  unlock,
    output logic                  err,
    output logic                  alarm,
    output logic                  prog_done,
    output logic [1:0]            fail_cnt
);

    localparam int DW   = $clog2(DIGITS + 1);
    localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [DW-1:0] DCNT_FULL  = DW'(DIGITS);
    localparam logic [TW-1:0] OPEN_LOAD  = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]    FAIL_LIMIT = 2'(MAX_FAIL);

    typedef enum logic [2:0] {IDLE, CHECK, FAIL, OPEN, LOCKOUT} state_t;

    state_t                state, next_state;
    logic [DW-1:0]         dcnt, dcnt_d;
    logic [TW-1:0]         timer, timer_d;
    logic [4*DIGITS-1:0]   code_reg, code_d;
    logic [1:0]            fail_d, fail_inc;
    logic                  shift_clr_d, unlock_d, err_d, alarm_d, prog_done_d;
    logic                  match, lock_trip, prog_ok, counting;

    assign match     = (dcnt == DCNT_FULL) && (code_i == code_reg);
    assign fail_inc  = fail_cnt + 2'd1;
    assign lock_trip = (fail_inc == FAIL_LIMIT);
    assign prog_ok   = (state == OPEN) && prog && !enter && (dcnt == DCNT_FULL);
    // ENTER takes priority over a digit strobe arriving in the same cycle.
    assign counting  = digit_valid && !enter && ((state == IDLE) || (state == OPEN));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enter) next_state = CHECK;
            CHECK:   next_state = match ? OPEN : (lock_trip ? LOCKOUT : FAIL);
            FAIL:    next_state = IDLE;
            OPEN: begin
                if (enter)                 next_state = IDLE;
                else if (prog_ok)          next_state = OPEN;
                else if (timer == '0)      next_state = IDLE;
            end
            LOCKOUT: if (timer == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        unlock_d    = (next_state == OPEN);
        err_d       = (next_state == FAIL);
        alarm_d     = (next_state == LOCKOUT);
        prog_done_d = prog_ok;
        shift_clr_d = ((next_state == IDLE) && (state != IDLE)) || prog_ok;

        dcnt_d = dcnt;
        if (shift_clr_d)                         dcnt_d = '0;
        else if (counting && dcnt != DCNT_FULL)  dcnt_d = dcnt + DW'(1);

        code_d = prog_ok ? code_i : code_reg;

        timer_d = timer;
        fail_d  = fail_cnt;
        case (state)
            CHECK: begin
                if (match) begin
                    timer_d = OPEN_LOAD;
                    fail_d  = 2'd0;
                end else begin
                    fail_d = fail_inc;
                    if (lock_trip) timer_d = LOCK_LOAD;
                end
            end
            OPEN: begin
                if (prog_ok)            timer_d = OPEN_LOAD;
                else if (timer != '0)   timer_d = timer - TW'(1);
            end
            LOCKOUT: begin
                if (timer != '0) timer_d = timer - TW'(1);
                else             fail_d  = 2'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            shift_clr <= 1'b0;
            unlock    <= 1'b0;
            err       <= 1'b0;
            alarm     <= 1'b0;
            prog_done <= 1'b0;
            fail_cnt  <= 2'd0;
            dcnt      <= '0;
            timer     <= '0;
            code_reg  <= DEFAULT_CODE;
        end else begin
            shift_clr <= shift_clr_d;
            unlock    <= unlock_d;
            err       <= err_d;
            alarm     <= alarm_d;
            prog_done <= prog_done_d;
            fail_cnt  <= fail_d;
            dcnt      <= dcnt_d;
            timer     <= timer_d;
            code_reg  <= code_d;
        end
    end

endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench for lock_controller: stimulus queues the expected output
// events (cycle + output vector), a negedge monitor pops and compares them.
module tb_lock_controller;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        digit_valid = 1'b0;
    logic        enter = 1'b0;
    logic        prog = 1'b0;
    logic [15:0] code_i = 16'h0000;
    logic        shift_clr, unlock, err, alarm, prog_done;
    logic [1:0]  fail_cnt;

    lock_controller dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .digit_valid (digit_valid),
        .enter       (enter),
        .prog        (prog),
        .code_i      (code_i),
        .shift_clr   (shift_clr),
        .unlock      (unlock),
        .err         (err),
        .alarm       (alarm),
        .prog_done   (prog_done),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;

    // Output vector layout: {shift_clr, unlock, err, alarm, prog_done, fail_cnt[1:0]}
    localparam logic [6:0] SC = 7'b1000000;
    localparam logic [6:0] UN = 7'b0100000;
    localparam logic [6:0] ER = 7'b0010000;
    localparam logic [6:0] AL = 7'b0001000;
    localparam logic [6:0] PD = 7'b0000100;

    typedef struct {
        int         cyc;
        logic [6:0] outs;
    } ev_t;

    ev_t        q[$];
    int         cyc = 0;
    int         n_total = 0;
    int         n_pass = 0;
    logic [6:0] obs;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every cycle with any pulse/level output active is one event.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (clr_n) begin
                obs = {shift_clr, unlock, err, alarm, prog_done, fail_cnt};
                if (obs[6:2] != 5'b0) begin
                    n_total++;
                    if (q.size() == 0) begin
                        $display("FAIL unexpected_event cyc=%0d outs=%b, required no event", cyc, obs);
                    end else begin
                        e = q.pop_front();
                        if (e.cyc == cyc && e.outs == obs)
                            n_pass++;
                        else
                            $display("FAIL event got cyc=%0d outs=%b, required cyc=%0d outs=%b",
                                     cyc, obs, e.cyc, e.outs);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [6:0] v);
        ev_t e;
        e.cyc  = c;
        e.outs = v;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s got=%b required=%b", name, act, exp);
    endtask

    task automatic drain(input string name, input int budget);
        int b = 0;
        while (q.size() != 0 && b < budget) begin
            tick();
            b++;
        end
        tick();
        tick();
        n_total++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL %s_drain got %0d pending events, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic digits(input logic [15:0] c, input int n);
        code_i = c;
        for (int i = 0; i < n; i++) begin
            digit_valid = 1'b1;
            tick();
            digit_valid = 1'b0;
        end
    endtask

    // n is the cycle count at drive time; the edge at n+1 samples ENTER.
    task automatic press_enter(output int n);
        n = cyc;
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic attempt_open(input logic [15:0] c, input string name);
        int n;
        digits(c, 4);
        press_enter(n);
        for (int k = 0; k < 8; k++) push(n + 2 + k, UN);
        push(n + 10, SC);
        drain(name, 30);
    endtask

    task automatic attempt_miss(input logic [15:0] c, input int nd, input int fc, input string name);
        int n;
        digits(c, nd);
        press_enter(n);
        push(n + 2, ER | 7'(fc));
        push(n + 3, SC | 7'(fc));
        drain(name, 20);
    endtask

    initial begin
        int n;

        // Reset state
        #1;
        check("reset_outs", {shift_clr, unlock, err, alarm, prog_done, fail_cnt}, 7'b0);
        tick();
        tick();
        clr_n = 1'b1;
        tick();
        check("idle_outs", {shift_clr, unlock, err, alarm, prog_done, fail_cnt}, 7'b0);

        // Correct default code opens for 8 cycles then relocks
        attempt_open(16'h1234, "open_default");

        // Wrong code, then repeated misses into lockout with ignored inputs
        attempt_miss(16'h1235, 4, 1, "miss1");
        attempt_miss(16'h1111, 4, 2, "miss2");
        digits(16'h9999, 4);
        press_enter(n);
        for (int k = 0; k < 16; k++) push(n + 2 + k, AL | 7'd3);
        push(n + 18, SC);
        tick();
        tick();
        tick();
        code_i = 16'h1234;
        digit_valid = 1'b1;
        enter = 1'b1;
        prog = 1'b1;
        tick();
        tick();
        tick();
        digit_valid = 1'b0;
        enter = 1'b0;
        prog = 1'b0;
        drain("lockout", 40);

        // Too few digits is a failure; ENTER beats a simultaneous digit strobe
        attempt_miss(16'h1234, 3, 1, "three_digits");
        digits(16'h1234, 3);
        n = cyc;
        digit_valid = 1'b1;
        enter = 1'b1;
        tick();
        digit_valid = 1'b0;
        enter = 1'b0;
        push(n + 2, ER | 7'd2);
        push(n + 3, SC | 7'd2);
        drain("enter_with_digit", 20);

        // Open, enter new code, prog extends the open window
        digits(16'h1234, 4);
        press_enter(n);
        for (int k = 2; k <= 6; k++) push(n + k, UN);
        push(n + 7, SC | UN | PD);
        for (int k = 8; k <= 14; k++) push(n + k, UN);
        push(n + 15, SC);
        tick();
        digits(16'hBEEF, 4);
        prog = 1'b1;
        tick();
        prog = 1'b0;
        drain("prog_beef", 30);

        // New code opens; early ENTER with prog relocks without storing
        digits(16'hBEEF, 4);
        press_enter(n);
        push(n + 2, UN);
        push(n + 3, UN);
        push(n + 4, SC);
        tick();
        tick();
        code_i = 16'h5555;
        enter = 1'b1;
        prog = 1'b1;
        tick();
        enter = 1'b0;
        prog = 1'b0;
        drain("early_relock", 20);
        attempt_miss(16'h1234, 4, 1, "old_code_fails");
        attempt_miss(16'h5555, 4, 2, "no_store_on_enter");

        // Reset mid-OPEN restores the default code
        digits(16'hBEEF, 4);
        press_enter(n);
        for (int k = 0; k < 8; k++) push(n + 2 + k, UN);
        push(n + 10, SC);
        tick();
        tick();
        tick();
        clr_n = 1'b0;
        q.delete();
        #1;
        check("reset_mid_open", {shift_clr, unlock, err, alarm, prog_done, fail_cnt}, 7'b0);
        tick();
        clr_n = 1'b1;
        tick();
        attempt_open(16'h1234, "default_after_reset");

        // Reset mid-LOCKOUT clears alarm and failure count
        attempt_miss(16'h0001, 4, 1, "lk_miss1");
        attempt_miss(16'h0002, 4, 2, "lk_miss2");
        digits(16'h0003, 4);
        press_enter(n);
        for (int k = 0; k < 16; k++) push(n + 2 + k, AL | 7'd3);
        push(n + 18, SC);
        for (int k = 0; k < 5; k++) tick();
        clr_n = 1'b0;
        q.delete();
        #1;
        check("reset_mid_lockout", {shift_clr, unlock, err, alarm, prog_done, fail_cnt}, 7'b0);
        tick();
        clr_n = 1'b1;
        tick();
        attempt_miss(16'h1235, 4, 1, "miss_after_lockout_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
